freelist_arb: RTL and testbench

FREELIST_ARB -- requirements
Module: freelist_arb

---
 rtl/freelist_arb.sv | 122 ++++++++++++
 tb/tb_freelist_arb.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/freelist_arb.sv
// freelist_arb: binds requesters round-robin to valid freelist read ports, and runs a flush/wait sequence.
// Defining FREELIST_ARB_STAT_EN adds a saturating 16-bit stall_cnt output.
module freelist_arb #(
  parameter int REQ  = 4,
  parameter int READ = 2,
  parameter int DATA = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REQ-1:0]            req,
  output logic [REQ-1:0]            gnt,
  output logic [REQ-1:0][DATA-1:0]  gnt_tag,
  input  logic                      flush_req,
  output logic                      ready,
  output logic [READ-1:0]           fl_re_,
  input  logic [READ-1:0][DATA-1:0] fl_rd,
  input  logic [READ-1:0]           fl_v,
  output logic                      fl_flush_,
  input  logic                      fl_busy
`ifdef FREELIST_ARB_STAT_EN
  ,
  output logic [15:0]               stall_cnt
`endif
);

  localparam int PW = (REQ > 1) ? $clog2(REQ) : 1;
  localparam int PL = (READ > 1) ? $clog2(READ) : 1;

  typedef enum logic [1:0] {IDLE, FLUSH, WAIT} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic          ready_q, ready_d;

  logic          grant_en;
  logic [PW-1:0] idx;
  logic [PL-1:0] port;
  logic          found;
  logic [READ-1:0] avail;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      ready_q  <= ready_d;
    end
  end

  // A new flush request while waiting restarts the sequence; one during FLUSH is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush_req) state_d = FLUSH;
      FLUSH:   state_d = WAIT;
      WAIT: begin
        if (flush_req)     state_d = FLUSH;
        else if (!fl_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_comb begin
    grant_en  = !reset && (state_q == IDLE) && !flush_req;
    ready     = ready_q;
    fl_flush_ = reset || (state_q != FLUSH);
    gnt       = '0;
    gnt_tag   = '0;
    fl_re_    = '1;
    rr_ptr_d  = rr_ptr_q;
    avail     = fl_v;
    idx       = '0;
    port      = '0;
    found     = 1'b0;
    if (grant_en) begin
      for (int j = 0; j < REQ; j++) begin
        idx   = PW'((int'(rr_ptr_q) + j) % REQ);
        found = 1'b0;
        port  = '0;
        if (req[idx]) begin
          // Lowest-index port that is still valid and not yet bound this cycle.
          for (int k = 0; k < READ; k++) begin
            if (!found && avail[k]) begin
              found = 1'b1;
              port  = PL'(k);
            end
          end
          if (found) begin
            gnt[idx]     = 1'b1;
            gnt_tag[idx] = fl_rd[port];
            fl_re_[port] = 1'b0;
            avail[port]  = 1'b0;
            rr_ptr_d     = (idx == PW'(REQ - 1)) ? '0 : idx + 1'b1;
          end
        end
      end
    end
  end

`ifdef FREELIST_ARB_STAT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == IDLE) && (|req) && (gnt == '0) && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_freelist_arb.sv
// tb_freelist_arb: directed vectors for freelist_arb (REQ=4, READ=2, DATA=4) with a queue-based scoreboard.
// Works with or without FREELIST_ARB_STAT_EN.
module tb_freelist_arb;

  logic             clk;
  logic             reset;
  logic [3:0]       req;
  logic [3:0]       gnt;
  logic [3:0][3:0]  gnt_tag;
  logic             flush_req;
  logic             ready;
  logic [1:0]       fl_re_;
  logic [1:0][3:0]  fl_rd;
  logic [1:0]       fl_v;
  logic             fl_flush_;
  logic             fl_busy;
`ifdef FREELIST_ARB_STAT_EN
  logic [15:0]      stall_cnt;
`endif

  int checks = 0;
  int fails  = 0;

  typedef struct {
    string       name;
    logic [3:0]  gnt;
    logic [15:0] tag;
    logic [1:0]  re;
    logic        rdy;
    logic        fn;
    int          stall;
  } exp_t;

  exp_t exp_q[$];

  freelist_arb #(.REQ(4), .READ(2), .DATA(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .gnt_tag   (gnt_tag),
    .flush_req (flush_req),
    .ready     (ready),
    .fl_re_    (fl_re_),
    .fl_rd     (fl_rd),
    .fl_v      (fl_v),
    .fl_flush_ (fl_flush_),
    .fl_busy   (fl_busy)
`ifdef FREELIST_ARB_STAT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp({e.name, "_gnt"},     32'(gnt),            32'(e.gnt));
    cmp({e.name, "_gnt_tag"}, 32'(gnt_tag),        32'(e.tag));
    cmp({e.name, "_fl_re_"},  32'(fl_re_),         32'(e.re));
    cmp({e.name, "_ready"},   32'(ready),          32'(e.rdy));
    cmp({e.name, "_flush_"},  32'(fl_flush_),      32'(e.fn));
`ifdef FREELIST_ARB_STAT_EN
    if (e.stall >= 0) cmp({e.name, "_stall_cnt"}, 32'(stall_cnt), e.stall);
`endif
  endtask

  // Drive one cycle of inputs just after the edge and record what the outputs must show that cycle.
  task automatic applyStimulus(input string name, input logic rst, input logic [3:0] r,
                               input logic [1:0] v, input logic [7:0] rd, input logic fr,
                               input logic busy, input logic [3:0] eg, input logic [15:0] et,
                               input logic [1:0] ere, input logic erdy, input logic efn,
                               input int est);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    req       = r;
    fl_v      = v;
    fl_rd     = rd;
    flush_req = fr;
    fl_busy   = busy;
    e.name = name; e.gnt = eg; e.tag = et; e.re = ere; e.rdy = erdy; e.fn = efn; e.stall = est;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; req = '0; fl_v = '0; fl_rd = '0; flush_req = 1'b0; fl_busy = 1'b0;

    //            name             rst req      v      rd     fr    busy  gnt      tag       re     rdy   fn    stall
    applyStimulus("reset",         1, 4'b1111, 2'b11, 8'h53, 1'b0, 1'b0, 4'b0000, 16'h0000, 2'b11, 1'b1, 1'b1, -1);
    applyStimulus("rr_first",      0, 4'b1111, 2'b11, 8'h53, 1'b0, 1'b0, 4'b0011, 16'h0053, 2'b00, 1'b1, 1'b1, -1);
    applyStimulus("rr_second",     0, 4'b1111, 2'b11, 8'h53, 1'b0, 1'b0, 4'b1100, 16'h5300, 2'b00, 1'b1, 1'b1, -1);
    applyStimulus("port1_only",    0, 4'b0001, 2'b10, 8'h90, 1'b0, 1'b0, 4'b0001, 16'h0009, 2'b01, 1'b1, 1'b1, -1);
    applyStimulus("setup_rr3",     0, 4'b0100, 2'b11, 8'h53, 1'b0, 1'b0, 4'b0100, 16'h0300, 2'b10, 1'b1, 1'b1, -1);
    applyStimulus("wrap_rr3",      0, 4'b1001, 2'b11, 8'h76, 1'b0, 1'b0, 4'b1001, 16'h6007, 2'b00, 1'b1, 1'b1, -1);
    applyStimulus("rr_is_1",       0, 4'b1111, 2'b01, 8'h76, 1'b0, 1'b0, 4'b0010, 16'h0060, 2'b10, 1'b1, 1'b1, -1);
    for (int i = 0; i < 3; i++)
      applyStimulus("no_valid",    0, 4'b1111, 2'b00, 8'h76, 1'b0, 1'b0, 4'b0000, 16'h0000, 2'b11, 1'b1, 1'b1, -1);
    applyStimulus("flush_req",     0, 4'b1111, 2'b11, 8'h53, 1'b1, 1'b0, 4'b0000, 16'h0000, 2'b11, 1'b1, 1'b1, 3);
    applyStimulus("flush_state",   0, 4'b1111, 2'b11, 8'h53, 1'b1, 1'b1, 4'b0000, 16'h0000, 2'b11, 1'b0, 1'b0, -1);
    for (int i = 0; i < 4; i++)
      applyStimulus("wait_busy",   0, 4'b1111, 2'b11, 8'h53, 1'b0, 1'b1, 4'b0000, 16'h0000, 2'b11, 1'b0, 1'b1, -1);
    applyStimulus("wait_release",  0, 4'b1111, 2'b11, 8'h53, 1'b0, 1'b0, 4'b0000, 16'h0000, 2'b11, 1'b0, 1'b1, -1);
    applyStimulus("idle_return",   0, 4'b1111, 2'b11, 8'h53, 1'b0, 1'b0, 4'b1100, 16'h5300, 2'b00, 1'b1, 1'b1, -1);
    applyStimulus("rr_set1",       0, 4'b0001, 2'b01, 8'h53, 1'b0, 1'b0, 4'b0001, 16'h0003, 2'b10, 1'b1, 1'b1, -1);
    applyStimulus("flush2_req",    0, 4'b1111, 2'b11, 8'h53, 1'b1, 1'b0, 4'b0000, 16'h0000, 2'b11, 1'b1, 1'b1, -1);
    applyStimulus("flush2_state",  0, 4'b1111, 2'b11, 8'h53, 1'b0, 1'b1, 4'b0000, 16'h0000, 2'b11, 1'b0, 1'b0, -1);
    applyStimulus("reflush_wait",  0, 4'b1111, 2'b11, 8'h53, 1'b1, 1'b1, 4'b0000, 16'h0000, 2'b11, 1'b0, 1'b1, -1);
    applyStimulus("reflush_state", 0, 4'b1111, 2'b11, 8'h53, 1'b0, 1'b1, 4'b0000, 16'h0000, 2'b11, 1'b0, 1'b0, -1);
    applyStimulus("wait_reset",    1, 4'b1111, 2'b11, 8'h53, 1'b0, 1'b1, 4'b0000, 16'h0000, 2'b11, 1'b0, 1'b1, -1);
    applyStimulus("post_reset",    0, 4'b1111, 2'b11, 8'h53, 1'b0, 1'b1, 4'b0011, 16'h0053, 2'b00, 1'b1, 1'b1, 0);

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
